// File: rtl/param_cam.sv
// param_cam - parameterised content-addressable memory.
//
// CAM_DEPTH entries of CAM_WIDTH-bit keys, each with a valid bit.
// Searches compare a key against all valid entries and return a registered
// result one cycle later. The mutating operations are flush, invalidate,
// write and insert. They are mutually exclusive per cycle and resolved in
// that priority order. Insert auto-allocates the lowest free slot. When the
// CAM is full, insert evicts the slot at a round-robin victim pointer.
//
// Optional feature: define CAM_TERNARY_EN to add i_search_mask. A set mask
// bit excludes that key bit from the compare.
//
// Ports:
//   i_clk, i_rst_n     clock; asynchronous active-low reset
//   i_search           search request, key on i_contents
//   i_contents         key for search / write / insert
//   i_write_en         store i_contents at i_wr_addr and set its valid bit
//   i_wr_addr          address for write and invalidate
//   i_insert_en        auto-allocate a slot and store i_contents
//   i_inval_en         clear the valid bit at i_wr_addr
//   i_flush            clear all valid bits
//   i_search_mask      (CAM_TERNARY_EN only) per-bit don't-care for search
//   o_match            search hit
//   o_match_addr       lowest matching index (0 on miss)
//   o_multi_match      more than one valid entry matched
//   o_search_done      search result valid (holds until the next result)
//   o_valid_status     per-entry valid bits
//   o_full, o_empty    all valid / none valid (combinational)
//   o_ins_done         one-cycle pulse after an executed insert
//   o_ins_addr         slot used by that insert
//   o_evicted          that slot was previously valid
module param_cam #(
  parameter int CAM_DEPTH = 8,
  parameter int CAM_WIDTH = 48,
  parameter int CAM_PTR   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_search,
  input  logic [CAM_WIDTH-1:0] i_contents,
  input  logic                 i_write_en,
  input  logic [CAM_PTR-1:0]   i_wr_addr,
  input  logic                 i_insert_en,
  input  logic                 i_inval_en,
  input  logic                 i_flush,
`ifdef CAM_TERNARY_EN
  input  logic [CAM_WIDTH-1:0] i_search_mask,
`endif
  output logic                 o_match,
  output logic [CAM_PTR-1:0]   o_match_addr,
  output logic                 o_multi_match,
  output logic                 o_search_done,
  output logic [CAM_DEPTH-1:0] o_valid_status,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_ins_done,
  output logic [CAM_PTR-1:0]   o_ins_addr,
  output logic                 o_evicted
);

  logic [CAM_WIDTH-1:0] mem_q [CAM_DEPTH];
  logic [CAM_DEPTH-1:0] valid_q, valid_d;
  logic [CAM_PTR-1:0]   victim_q;

  logic [CAM_WIDTH-1:0] care_mask;
  logic [CAM_DEPTH-1:0] hit_vec;
  logic                 hit_any, hit_multi;
  logic [CAM_PTR-1:0]   hit_idx;
  logic                 hit_found;

  logic [CAM_PTR-1:0]   free_idx;
  logic                 free_found;
  logic                 full_c;

  logic                 do_flush, do_inval, do_write, do_insert;
  logic                 addr_ok;
  logic [CAM_PTR-1:0]   ins_addr_c;

`ifdef CAM_TERNARY_EN
  assign care_mask = ~i_search_mask;
`else
  assign care_mask = '1;
`endif

  // Match against the current (pre-edge) storage, so a search in the same
  // cycle as a mutation sees the old contents.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      hit_vec[i] = valid_q[i] && (((mem_q[i] ^ i_contents) & care_mask) == '0);
    end
  end

  always_comb begin
    hit_idx   = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      if (hit_vec[i] && !hit_found) begin
        hit_idx   = CAM_PTR'(i);
        hit_found = 1'b1;
      end
    end
  end

  assign hit_any   = |hit_vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign hit_multi = |(hit_vec & (hit_vec - CAM_DEPTH'(1)));

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = CAM_PTR'(i);
        free_found = 1'b1;
      end
    end
  end

  assign full_c = &valid_q;

  // One mutating op per cycle: flush > invalidate > write > insert.
  assign do_flush  = i_flush;
  assign do_inval  = !i_flush && i_inval_en;
  assign do_write  = !i_flush && !i_inval_en && i_write_en;
  assign do_insert = !i_flush && !i_inval_en && !i_write_en && i_insert_en;
  assign addr_ok   = int'(i_wr_addr) < CAM_DEPTH;

  assign ins_addr_c = full_c ? victim_q : free_idx;

  always_comb begin
    valid_d = valid_q;
    if (do_flush) begin
      valid_d = '0;
    end else begin
      for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
        if (do_inval && addr_ok && i_wr_addr == CAM_PTR'(i)) valid_d[i] = 1'b0;
        if (do_write && addr_ok && i_wr_addr == CAM_PTR'(i)) valid_d[i] = 1'b1;
        if (do_insert && ins_addr_c == CAM_PTR'(i))          valid_d[i] = 1'b1;
      end
    end
  end

  // Key storage has no reset; stale keys are hidden by their valid bits.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      if ((do_write && addr_ok && i_wr_addr == CAM_PTR'(i)) ||
          (do_insert && ins_addr_c == CAM_PTR'(i))) begin
        mem_q[i] <= i_contents;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      victim_q      <= '0;
      o_match       <= 1'b0;
      o_match_addr  <= '0;
      o_multi_match <= 1'b0;
      o_search_done <= 1'b0;
      o_ins_done    <= 1'b0;
      o_ins_addr    <= '0;
      o_evicted     <= 1'b0;
    end else begin
      valid_q <= valid_d;

      if (i_search) begin
        o_search_done <= 1'b1;
        o_match       <= hit_any;
        o_match_addr  <= hit_idx;
        o_multi_match <= hit_multi;
      end

      o_ins_done <= do_insert;
      if (do_insert) begin
        o_ins_addr <= ins_addr_c;
        o_evicted  <= full_c;
        if (full_c) begin
          victim_q <= (victim_q == CAM_PTR'(CAM_DEPTH - 1)) ? '0
                                                           : victim_q + CAM_PTR'(1);
        end
      end
    end
  end

  assign o_valid_status = valid_q;
  assign o_full         = full_c;
  assign o_empty        = ~|valid_q;

endmodule

// File: tb/tb_param_cam.sv
module tb_param_cam;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_search;
  logic [47:0] i_contents;
  logic        i_write_en;
  logic [2:0]  i_wr_addr;
  logic        i_insert_en;
  logic        i_inval_en;
  logic        i_flush;
`ifdef CAM_TERNARY_EN
  logic [47:0] i_search_mask;
`endif
  logic        o_match;
  logic [2:0]  o_match_addr;
  logic        o_multi_match;
  logic        o_search_done;
  logic [7:0]  o_valid_status;
  logic        o_full;
  logic        o_empty;
  logic        o_ins_done;
  logic [2:0]  o_ins_addr;
  logic        o_evicted;

  int errors = 0;
  int checks = 0;

  param_cam #(.CAM_DEPTH(8), .CAM_WIDTH(48), .CAM_PTR(3)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_search       (i_search),
    .i_contents     (i_contents),
    .i_write_en     (i_write_en),
    .i_wr_addr      (i_wr_addr),
    .i_insert_en    (i_insert_en),
    .i_inval_en     (i_inval_en),
    .i_flush        (i_flush),
`ifdef CAM_TERNARY_EN
    .i_search_mask  (i_search_mask),
`endif
    .o_match        (o_match),
    .o_match_addr   (o_match_addr),
    .o_multi_match  (o_multi_match),
    .o_search_done  (o_search_done),
    .o_valid_status (o_valid_status),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_ins_done     (o_ins_done),
    .o_ins_addr     (o_ins_addr),
    .o_evicted      (o_evicted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_search    = 1'b0;
    i_write_en  = 1'b0;
    i_insert_en = 1'b0;
    i_inval_en  = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle();
    i_contents = '0;
    i_wr_addr  = '0;
`ifdef CAM_TERNARY_EN
    i_search_mask = '0;
`endif
    #3;
    checks++; if (o_valid_status !== 8'h00) begin errors++; $display("FAIL reset_valid got=%h exp=00", o_valid_status); end
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b exp=10", o_empty, o_full); end
    checks++; if ({o_match, o_match_addr, o_multi_match, o_search_done} !== 6'b0) begin errors++; $display("FAIL reset_search got=%b exp=0", {o_match, o_match_addr, o_multi_match, o_search_done}); end
    checks++; if ({o_ins_done, o_ins_addr, o_evicted} !== 5'b0) begin errors++; $display("FAIL reset_ins got=%b exp=0", {o_ins_done, o_ins_addr, o_evicted}); end
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_search();
    i_write_en = 1'b1; i_wr_addr = 3'd3; i_contents = 48'hAAAA;
    step();
    idle();
    checks++; if (o_valid_status !== 8'h08) begin errors++; $display("FAIL write_valid got=%h exp=08", o_valid_status); end
    i_search = 1'b1; i_contents = 48'hAAAA;
    step();
    idle();
    checks++; if (o_search_done !== 1'b1 || o_match !== 1'b1 || o_match_addr !== 3'd3 || o_multi_match !== 1'b0)
      begin errors++; $display("FAIL search_aaaa got done=%b m=%b a=%0d mm=%b exp 1 1 3 0", o_search_done, o_match, o_match_addr, o_multi_match); end
    // miss
    i_search = 1'b1; i_contents = 48'hBBBB;
    step();
    idle();
    checks++; if (o_match !== 1'b0 || o_match_addr !== 3'd0 || o_multi_match !== 1'b0)
      begin errors++; $display("FAIL search_miss got m=%b a=%0d mm=%b exp 0 0 0", o_match, o_match_addr, o_multi_match); end
  endtask

  task automatic test_multi_match();
    i_write_en = 1'b1; i_wr_addr = 3'd2; i_contents = 48'h55;
    step();
    i_wr_addr = 3'd6;
    step();
    idle();
    i_search = 1'b1; i_contents = 48'h55;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd2 || o_multi_match !== 1'b1)
      begin errors++; $display("FAIL multi_match got m=%b a=%0d mm=%b exp 1 2 1", o_match, o_match_addr, o_multi_match); end
    // result holds with no new search
    step();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd2 || o_multi_match !== 1'b1)
      begin errors++; $display("FAIL result_hold got m=%b a=%0d mm=%b exp 1 2 1", o_match, o_match_addr, o_multi_match); end
    i_inval_en = 1'b1; i_wr_addr = 3'd2;
    step();
    idle();
    checks++; if (o_valid_status !== 8'h48) begin errors++; $display("FAIL inval_valid got=%h exp=48", o_valid_status); end
    i_search = 1'b1; i_contents = 48'h55;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd6 || o_multi_match !== 1'b0)
      begin errors++; $display("FAIL after_inval got m=%b a=%0d mm=%b exp 1 6 0", o_match, o_match_addr, o_multi_match); end
  endtask

  task automatic test_insert_evict();
    i_flush = 1'b1;
    step();
    idle();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", o_empty); end
    for (int i = 0; i < 8; i++) begin
      i_insert_en = 1'b1; i_contents = 48'h100 + 48'(i);
      step();
      checks++; if (o_ins_done !== 1'b1 || o_ins_addr !== 3'(i) || o_evicted !== 1'b0)
        begin errors++; $display("FAIL insert_%0d got d=%b a=%0d e=%b exp 1 %0d 0", i, o_ins_done, o_ins_addr, o_evicted, i); end
    end
    checks++; if (o_full !== 1'b1 || o_empty !== 1'b0) begin errors++; $display("FAIL full_flag got f=%b e=%b exp 1 0", o_full, o_empty); end
    // full: evictions walk the victim pointer 0,1,...,7 then wrap to 0
    for (int i = 0; i < 9; i++) begin
      i_insert_en = 1'b1; i_contents = 48'h200 + 48'(i);
      step();
      checks++; if (o_ins_done !== 1'b1 || o_ins_addr !== 3'(i % 8) || o_evicted !== 1'b1)
        begin errors++; $display("FAIL evict_%0d got d=%b a=%0d e=%b exp 1 %0d 1", i, o_ins_done, o_ins_addr, o_evicted, i % 8); end
      if (i == 1) begin
        idle();
        step();
        checks++; if (o_ins_done !== 1'b0) begin errors++; $display("FAIL ins_pulse got=%b exp=0", o_ins_done); end
      end
    end
    idle();
    // evicted slot 0 now holds the last key
    i_search = 1'b1; i_contents = 48'h208;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd0)
      begin errors++; $display("FAIL evict_key got m=%b a=%0d exp 1 0", o_match, o_match_addr); end
  endtask

  task automatic test_read_before_write();
    i_flush = 1'b1;
    step();
    idle();
    i_search = 1'b1; i_write_en = 1'b1; i_wr_addr = 3'd0; i_contents = 48'h11;
    step();
    idle();
    checks++; if (o_search_done !== 1'b1 || o_match !== 1'b0)
      begin errors++; $display("FAIL rbw_first got done=%b m=%b exp 1 0", o_search_done, o_match); end
    i_search = 1'b1; i_contents = 48'h11;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd0)
      begin errors++; $display("FAIL rbw_repeat got m=%b a=%0d exp 1 0", o_match, o_match_addr); end
  endtask

  task automatic test_flush_priority();
    i_flush = 1'b1; i_write_en = 1'b1; i_wr_addr = 3'd5; i_contents = 48'h77;
    step();
    idle();
    checks++; if (o_empty !== 1'b1 || o_valid_status !== 8'h00)
      begin errors++; $display("FAIL flush_vs_write got e=%b v=%h exp 1 00", o_empty, o_valid_status); end
    // write beats insert: insert dropped entirely
    i_write_en = 1'b1; i_insert_en = 1'b1; i_wr_addr = 3'd4; i_contents = 48'h99;
    step();
    idle();
    checks++; if (o_ins_done !== 1'b0 || o_valid_status !== 8'h10)
      begin errors++; $display("FAIL write_vs_insert got d=%b v=%h exp 0 10", o_ins_done, o_valid_status); end
    // invalidate beats write
    i_inval_en = 1'b1; i_write_en = 1'b1; i_wr_addr = 3'd4;
    step();
    idle();
    checks++; if (o_valid_status !== 8'h00)
      begin errors++; $display("FAIL inval_vs_write got v=%h exp 00", o_valid_status); end
  endtask

`ifdef CAM_TERNARY_EN
  task automatic test_ternary();
    i_write_en = 1'b1; i_wr_addr = 3'd1; i_contents = 48'h12F0;
    step();
    idle();
    i_search = 1'b1; i_contents = 48'h12FF; i_search_mask = 48'h000F;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd1)
      begin errors++; $display("FAIL ternary_hit got m=%b a=%0d exp 1 1", o_match, o_match_addr); end
    i_search = 1'b1; i_search_mask = '0;
    step();
    idle();
    checks++; if (o_match !== 1'b0) begin errors++; $display("FAIL ternary_nomask got m=%b exp 0", o_match); end
  endtask
`endif

  task automatic test_reset_mid_insert();
    i_write_en = 1'b1; i_wr_addr = 3'd7; i_contents = 48'h3C;
    step();
    i_write_en = 1'b0; i_search = 1'b1;
    step();
    idle();
    checks++; if (o_match !== 1'b1 || o_match_addr !== 3'd7)
      begin errors++; $display("FAIL pre_reset_hit got m=%b a=%0d exp 1 7", o_match, o_match_addr); end
    i_insert_en = 1'b1; i_contents = 48'h44;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_empty !== 1'b1 || o_match !== 1'b0 || o_search_done !== 1'b0)
      begin errors++; $display("FAIL async_reset got e=%b m=%b d=%b exp 1 0 0", o_empty, o_match, o_search_done); end
    step();
    checks++; if (o_ins_done !== 1'b0) begin errors++; $display("FAIL reset_ins_in got=%b exp=0", o_ins_done); end
    idle();
    i_rst_n = 1'b1;
    step();
    checks++; if (o_ins_done !== 1'b0 || o_empty !== 1'b1)
      begin errors++; $display("FAIL reset_ins_after got d=%b e=%b exp 0 1", o_ins_done, o_empty); end
  endtask

  initial begin
    test_reset();
    test_write_search();
    test_multi_match();
    test_insert_evict();
    test_read_before_write();
    test_flush_priority();
`ifdef CAM_TERNARY_EN
    test_ternary();
`endif
    test_reset_mid_insert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 SHALL have parameter CAM_DEPTH, default 8: number of entries, any value >= 2, not restricted to powers of two.
REQ-002 SHALL have parameter CAM_WIDTH, default 48: key width in bits.
REQ-003 SHALL have parameter CAM_PTR, default 3: address width; SHALL satisfy 2**CAM_PTR >= CAM_DEPTH.
REQ-004 SHALL have port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_search, input, 1: search request.
REQ-007 SHALL have port i_contents, input, CAM_WIDTH: key for search, write and insert.
REQ-008 SHALL have port i_write_en, input, 1: write i_contents to i_wr_addr.
REQ-009 SHALL have port i_wr_addr, input, CAM_PTR: address for write and invalidate.
REQ-010 SHALL have port i_insert_en, input, 1: auto-allocate an entry and store i_contents.
REQ-011 SHALL have port i_inval_en, input, 1: clear the valid bit at i_wr_addr.
REQ-012 SHALL have port i_flush, input, 1: clear all valid bits.
REQ-013 SHALL have port o_match, output, 1: registered search hit.
REQ-014 SHALL have port o_match_addr, output, CAM_PTR: lowest matching index.
REQ-015 SHALL have port o_multi_match, output, 1: more than one valid entry matched.
REQ-016 SHALL have port o_search_done, output, 1: search result valid this cycle.
REQ-017 SHALL have port o_valid_status, output, CAM_DEPTH: per-entry valid bits, bit i = entry i.
REQ-018 SHALL have ports o_full and o_empty, output, 1 each: all entries valid / none valid.
REQ-019 SHALL have ports o_ins_done (1), o_ins_addr (CAM_PTR) and o_evicted (1), all outputs: insert completed, slot used, slot was previously valid.

Function
REQ-020 Search SHALL have 1-cycle latency: i_search sampled at edge N gives o_search_done, o_match, o_match_addr and o_multi_match valid after edge N; all four hold until the next search result.
REQ-021 Only valid entries SHALL match; the lowest index wins; on a miss o_match=0 and o_match_addr=0.
REQ-022 Mutating ops SHALL have priority flush > invalidate > write > insert; at most one executes per cycle and the rest are dropped with no side effect.
REQ-023 A search SHALL compare against pre-edge contents when it coincides with a mutating op (read-before-write).
REQ-024 Write SHALL store the key and set valid; i_wr_addr >= CAM_DEPTH SHALL be ignored.
REQ-025 Insert SHALL choose the lowest-index invalid entry; if the CAM is full it SHALL choose the entry at the round-robin victim pointer and assert o_evicted.
REQ-026 The victim pointer SHALL advance only on an eviction and SHALL wrap from CAM_DEPTH-1 to 0.
REQ-027 o_ins_done SHALL be a 1-cycle pulse after an executed insert, with o_ins_addr and o_evicted valid in the same cycle.
REQ-028 o_full and o_empty SHALL be combinational from the valid bits.

Reset
REQ-029 Asserting i_rst_n low SHALL immediately clear all valid bits, the victim pointer, o_match, o_match_addr, o_multi_match, o_search_done, o_ins_done, o_ins_addr and o_evicted; o_empty=1 and o_full=0.
REQ-030 Key storage SHALL NOT be reset; reset mid-operation SHALL abort the operation, and no result pulse follows deassertion.

Configuration
REQ-031 With macro CAM_TERNARY_EN defined, the module SHALL add input i_search_mask (CAM_WIDTH bits); a 1 in any bit excludes that bit from the compare.
REQ-032 Without CAM_TERNARY_EN, the port SHALL be absent and compares SHALL be exact on all CAM_WIDTH bits.

Verification
REQ-033 Reset, then write 0xAAAA at addr 3, then search 0xAAAA -> next cycle o_match=1, o_match_addr=3, o_multi_match=0.
REQ-034 Write 0x55 at addr 2 and at addr 6, then search 0x55 -> o_match_addr=2, o_multi_match=1; invalidate 2, then search again -> o_match_addr=6, o_multi_match=0.
REQ-035 Eight inserts from empty (CAM_DEPTH=8) -> o_ins_addr goes 0..7 with o_evicted=0 and o_full=1; ninth and tenth inserts -> addrs 0 then 1, with o_evicted=1.
REQ-036 Search 0x11 in the same cycle as a write of 0x11 to addr 0 -> miss; a repeat search -> hit at addr 0.
REQ-037 Assert flush and write in the same cycle -> o_empty=1 and the write is dropped; pull i_rst_n low mid-insert -> no o_ins_done pulse.
REQ-038 With CAM_TERNARY_EN, store 0x12F0 and search 0x12FF with mask 0x000F -> o_match=1.
